// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall masks, exception codes,
// handler vectors and controller state encoding.
package pipeline_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [31:0] EXC_NONE         = 32'h0;
    localparam logic [31:0] EXC_INT          = 32'h1;
    localparam logic [31:0] EXC_SYSCALL      = 32'h8;
    localparam logic [31:0] EXC_INST_INVALID = 32'ha;
    localparam logic [31:0] EXC_TRAP         = 32'hc;
    localparam logic [31:0] EXC_OVERFLOW     = 32'hd;
    localparam logic [31:0] EXC_ERET         = 32'he;

    localparam logic [31:0] INT_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0040;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HOLD = 1'b1
    } ctrl_state_t;

    // Unknown nonzero codes go to the general exception handler.
    function automatic logic [31:0] exc_target(input logic [31:0] code,
                                               input logic [31:0] epc,
                                               input logic [31:0] int_vec,
                                               input logic [31:0] exc_vec);
        logic [31:0] target;
        target = exc_vec;
        case (code)
            EXC_INT:  target = int_vec;
            EXC_ERET: target = epc;
            default:  target = exc_vec;
        endcase
        return target;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky timeout flag.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    input  logic flush,
    output logic stall_timeout
);
    localparam int CW = $clog2(STALL_TIMEOUT + 1);

    logic [CW-1:0] stall_cnt;

    // Count saturates so a permanently stuck pipeline never wraps back below the trip point.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt     <= '0;
            stall_timeout <= 1'b0;
        end else if (!stall_active || flush) begin
            stall_cnt <= '0;
        end else begin
            if (stall_cnt == CW'(STALL_TIMEOUT - 1))
                stall_timeout <= 1'b1;
            if (stall_cnt != CW'(STALL_TIMEOUT))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 6-stage pipeline.
// Optional PIPE_STALL_PERF_EN adds a free-running stalled-cycle counter on stall_cycles_o.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] INT_VECTOR    = INT_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEF,
    parameter int          HOLD_CYCLES   = 3,
    parameter int          STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout
`ifdef PIPE_STALL_PERF_EN
    ,
    output logic [31:0] stall_cycles_o
`endif
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    ctrl_state_t   state, state_nxt;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            hold_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN)
                hold_cnt <= HW'(HOLD_CYCLES - 1);
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Outputs are forced quiet while reset is asserted so no stage moves during reset.
    always_comb begin
        state_nxt = state;
        stall     = STALL_NONE;
        flush     = NoStop;
        new_pc    = 32'h0;
        if (!rst) begin
            if (state == S_RUN && excepttype_i != EXC_NONE) begin
                flush     = Stop;
                new_pc    = exc_target(excepttype_i, cp0_epc_i, INT_VECTOR, EXC_VECTOR);
                state_nxt = S_HOLD;
            end else begin
                if (stallreq_from_mem)
                    stall = STALL_MEM;
                else if (stallreq_from_ex)
                    stall = STALL_EX;
                else if (stallreq_from_id)
                    stall = STALL_ID;
                if (state == S_HOLD && hold_cnt == '0)
                    state_nxt = S_RUN;
            end
        end
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (stall != STALL_NONE),
        .flush        (flush),
        .stall_timeout(stall_timeout)
    );

`ifdef PIPE_STALL_PERF_EN
    // Lifetime statistic: flushes do not clear it, only reset does.
    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_o <= 32'h0;
        else if (stall != STALL_NONE)
            stall_cycles_o <= stall_cycles_o + 32'h1;
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, watchdog/perf sequences,
// and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;
    localparam int HOLD  = 3;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_req, ex_req, mem_req;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef PIPE_STALL_PERF_EN
    logic [31:0] stall_cycles;
`endif

    int tests = 0;
    int failures = 0;

    // Behavioural model state: remaining ignore cycles, current stall run length, sticky flag.
    int          m_hold_left;
    int          m_run_len;
    bit          m_timeout;
    logic [31:0] m_perf;

    typedef struct {
        logic        rst, id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .HOLD_CYCLES  (HOLD),
        .STALL_TIMEOUT(TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_from_id (id_req),
        .stallreq_from_ex (ex_req),
        .stallreq_from_mem(mem_req),
        .excepttype_i     (exc),
        .cp0_epc_i        (epc),
        .stall            (stall),
        .flush            (flush),
        .new_pc           (new_pc),
        .stall_timeout    (stall_timeout)
`ifdef PIPE_STALL_PERF_EN
        ,
        .stall_cycles_o   (stall_cycles)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, i, e, m, input logic [31:0] x, p,
                                input logic [5:0] st, input logic fl, input logic [31:0] pc);
        vec_t v;
        v.rst = r; v.id = i; v.ex = e; v.mem = m; v.exc = x; v.epc = p;
        v.st = st; v.fl = fl; v.pc = pc;
        return v;
    endfunction

    // One clock: drive on the falling edge, compare just after, then advance the model at the rising edge.
    task automatic applyStimulus(input vec_t v, input bit use_table, input string tag);
        bit          m_flush;
        logic [5:0]  m_stall;
        logic [31:0] m_pc;
        @(negedge clk);
        rst = v.rst; id_req = v.id; ex_req = v.ex; mem_req = v.mem; exc = v.exc; epc = v.epc;
        m_flush = 0; m_stall = 6'd0; m_pc = 32'd0;
        if (!v.rst) begin
            if (m_hold_left == 0 && v.exc != 0) begin
                m_flush = 1;
                if (v.exc == 32'h1)      m_pc = 32'h20;
                else if (v.exc == 32'he) m_pc = v.epc;
                else                     m_pc = 32'h40;
            end else begin
                // number of held stages: pc..id=3, +ex=4, +mem=5
                int n;
                n = v.mem ? 5 : v.ex ? 4 : v.id ? 3 : 0;
                m_stall = 6'((1 << n) - 1);
            end
        end
        #1;
        checkOutput({tag, ".stall"},   {26'd0, stall}, {26'd0, m_stall});
        checkOutput({tag, ".flush"},   {31'd0, flush}, {31'd0, m_flush});
        checkOutput({tag, ".new_pc"},  new_pc, m_pc);
        checkOutput({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, m_timeout});
`ifdef PIPE_STALL_PERF_EN
        checkOutput({tag, ".perf"},    stall_cycles, m_perf);
`endif
        if (use_table) begin
            checkOutput({tag, ".tbl_stall"}, {26'd0, stall}, {26'd0, v.st});
            checkOutput({tag, ".tbl_flush"}, {31'd0, flush}, {31'd0, v.fl});
            checkOutput({tag, ".tbl_pc"},    new_pc, v.pc);
        end
        @(posedge clk);
        if (v.rst) begin
            m_hold_left = 0; m_run_len = 0; m_timeout = 0; m_perf = 0;
        end else begin
            if (m_flush)               m_hold_left = HOLD;
            else if (m_hold_left > 0)  m_hold_left--;
            if (m_stall == 0 || m_flush) m_run_len = 0;
            else begin
                if (m_run_len == TMO - 1) m_timeout = 1;
                if (m_run_len < TMO) m_run_len++;
            end
            if (m_stall != 0) m_perf = m_perf + 1;
        end
    endtask

    task automatic step(input logic r, i, e, m, input logic [31:0] x, p, input string tag);
        applyStimulus(mk(r, i, e, m, x, p, 6'd0, 1'b0, 32'd0), 1'b0, tag);
    endtask

    initial begin
        m_hold_left = 0; m_run_len = 0; m_timeout = 0; m_perf = 0;
        rst = 1; id_req = 0; ex_req = 0; mem_req = 0; exc = 0; epc = 0;

        vecs.push_back(mk(1, 1, 1, 1, 32'h1,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,  32'h0,    6'b000111, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,  32'h0,    6'b001111, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 1, 32'h0,  32'h0,    6'b011111, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h1,  32'h0,    6'b000000, 1, 32'h20));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 1, 0, 0, 32'h8, 32'h0, 6'b000111, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'he,  32'h1234, 6'b000000, 1, 32'h1234));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0, 0, 32'h8, 32'h0, 6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h8,  32'h0,    6'b000000, 1, 32'h40));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 1, 0, 32'h5, 32'h0, 6'b001111, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 1, 32'h5,  32'h0,    6'b000000, 1, 32'h40));
        vecs.push_back(mk(0, 0, 0, 0, 32'ha,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'hc,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'hd,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'hd,  32'h0,    6'b000000, 1, 32'h40));
        vecs.push_back(mk(1, 0, 0, 1, 32'h0,  32'h0,    6'b000000, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'hc,  32'h0,    6'b000000, 1, 32'h40));

        foreach (vecs[i])
            applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Watchdog trip point and stickiness
        step(1, 0, 0, 0, 0, 0, "wd_rst");
        for (int i = 0; i < TMO - 1; i++)
            step(0, 0, 1, 0, 0, 0, "wd_run");
        #2 checkOutput("wd_before_trip", {31'd0, stall_timeout}, 32'd0);
        step(0, 0, 1, 0, 0, 0, "wd_run");
        #2 checkOutput("wd_tripped", {31'd0, stall_timeout}, 32'd1);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 0, 0, 0, "wd_idle");
        #2 checkOutput("wd_sticky", {31'd0, stall_timeout}, 32'd1);

`ifdef PIPE_STALL_PERF_EN
        step(1, 0, 0, 0, 0, 0, "perf_rst");
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, "perf_a");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "perf_b");
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, 0, "perf_c");
        #2 checkOutput("perf_total", stall_cycles, 32'd7);
`endif

        step(1, 0, 0, 0, 0, 0, "rnd_rst");
        for (int i = 0; i < 400; i++) begin
            logic [31:0] code;
            logic [31:0] codes [7];
            codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h0};
            code = 32'h0;
            if ($urandom_range(5) == 0) begin
                code = codes[$urandom_range(6)];
                if (code == 32'h0) code = $urandom | 32'h100;
            end
            step(($urandom_range(39) == 0), $urandom_range(1), ($urandom_range(2) != 0),
                 ($urandom_range(3) == 0), code, $urandom, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
